// File: rtl/muldiv_ctrl.sv
// M-extension sequencer: multicycle multiplier, signed wrapper around a shared divider.
// Latency MUL_CYCLES+1 (mul), 1 (div corner), start+divider+2 (div); result held in DONE until resp_ready.
module muldiv_ctrl #(
    parameter int MUL_CYCLES = 2,
    parameter int XLEN       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result,
    output logic            busy,
    input  logic            flush,
    output logic            div_start,
    output logic [XLEN-1:0] div_x,
    output logic [XLEN-1:0] div_y,
    input  logic            div_busy,
    input  logic            div_valid,
    input  logic [XLEN-1:0] div_q,
    input  logic [XLEN-1:0] div_r
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_WAIT,
        S_DIV_START,
        S_DIV_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    localparam logic [3:0]      MUL_CNT  = 4'(MUL_CYCLES);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    state_t          state, state_nxt;
    logic [3:0]      cnt;
    logic [1:0]      op_q;
    logic [XLEN-1:0] rs1_q, rs2_q;

    logic            accept;
    logic            req_is_div, req_signed, req_rem;
    logic            req_div0, req_ovf, req_special;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] mag1, mag2;

    logic            mul_a_sgn, mul_b_sgn;
    logic [2*XLEN-1:0] mul_a, mul_b, mul_prod;
    logic [XLEN-1:0] mul_res;

    logic            q_neg, r_neg;
    logic [XLEN-1:0] div_res;

    logic            res_load;
    logic [XLEN-1:0] res_nxt;

    // Request decode; corner-case results come straight from the request operands.
    always_comb begin
        accept      = (state == S_IDLE) && req_valid && !flush;
        req_is_div  = req_op[2];
        req_signed  = !req_op[0];
        req_rem     = req_op[1];
        req_div0    = (req_rs2 == '0);
        req_ovf     = req_signed && (req_rs1 == INT_MIN) && (req_rs2 == ALL_ONES);
        req_special = req_is_div && (req_div0 || req_ovf);
        if (req_div0)
            special_res = req_rem ? req_rs1 : ALL_ONES;
        else
            special_res = req_rem ? '0 : INT_MIN;
        mag1 = (req_signed && req_rs1[XLEN-1]) ? -req_rs1 : req_rs1;
        mag2 = (req_signed && req_rs2[XLEN-1]) ? -req_rs2 : req_rs2;
    end

    // Multiplier reads only latched operands so it can be timed as a multicycle path.
    always_comb begin
        mul_a_sgn = (op_q == 2'd1) || (op_q == 2'd2);
        mul_b_sgn = (op_q == 2'd1);
        mul_a     = {{XLEN{mul_a_sgn & rs1_q[XLEN-1]}}, rs1_q};
        mul_b     = {{XLEN{mul_b_sgn & rs2_q[XLEN-1]}}, rs2_q};
        mul_prod  = mul_a * mul_b;
        mul_res   = (op_q == 2'd0) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
    end

    always_comb begin
        q_neg   = !op_q[0] && (rs1_q[XLEN-1] ^ rs2_q[XLEN-1]);
        r_neg   = !op_q[0] && rs1_q[XLEN-1];
        if (op_q[1])
            div_res = r_neg ? -div_r : div_r;
        else
            div_res = q_neg ? -div_q : div_q;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        res_load   = 1'b0;
        res_nxt    = '0;
        req_ready  = (state == S_IDLE);
        busy       = (state != S_IDLE);
        resp_valid = (state == S_DONE);
        // A flushed op never starts the divider, so no start can land on a busy unit.
        div_start  = (state == S_DIV_START) && !flush;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!req_is_div) begin
                        state_nxt = S_MUL_WAIT;
                    end else if (req_special) begin
                        state_nxt = S_DONE;
                        res_load  = 1'b1;
                        res_nxt   = special_res;
                    end else begin
                        state_nxt = S_DIV_START;
                    end
                end
            end
            S_MUL_WAIT: begin
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (cnt == 4'd1) begin
                    state_nxt = S_DONE;
                    res_load  = 1'b1;
                    res_nxt   = mul_res;
                end
            end
            S_DIV_START: begin
                state_nxt = flush ? S_IDLE : S_DIV_WAIT;
            end
            S_DIV_WAIT: begin
                if (flush) begin
                    state_nxt = S_DRAIN;
                end else if (div_valid) begin
                    state_nxt = S_DONE;
                    res_load  = 1'b1;
                    res_nxt   = div_res;
                end
            end
            S_DONE: begin
                if (flush || resp_ready)
                    state_nxt = S_IDLE;
            end
            S_DRAIN: begin
                if (!div_busy && !div_start)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            op_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            div_x       <= '0;
            div_y       <= '0;
            resp_result <= '0;
        end else begin
            if (accept) begin
                op_q  <= req_op[1:0];
                rs1_q <= req_rs1;
                rs2_q <= req_rs2;
                cnt   <= MUL_CNT;
            end else if (state == S_MUL_WAIT && cnt != '0) begin
                cnt <= cnt - 4'd1;
            end
            // Magnitudes stay put for the whole divide.
            if (accept && req_is_div && !req_special) begin
                div_x <= mag1;
                div_y <= mag2;
            end
            if (res_load)
                resp_result <= res_nxt;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

    localparam int DIV_LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_rs1, req_rs2;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic        busy;
    logic        flush;
    logic        div_start;
    logic [31:0] div_x, div_y;
    logic        div_busy  = 1'b0;
    logic        div_valid = 1'b0;
    logic [31:0] div_q = '0;
    logic [31:0] div_r = '0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.MUL_CYCLES(2), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .busy(busy), .flush(flush),
        .div_start(div_start), .div_x(div_x), .div_y(div_y),
        .div_busy(div_busy), .div_valid(div_valid), .div_q(div_q), .div_r(div_r)
    );

    // Iterative divider model: busy for dm_lat cycles after a start, then a one-cycle valid.
    int          dm_lat = DIV_LAT;
    int          dm_cnt = 0;
    logic [31:0] dm_x = '0, dm_y = '0;
    always @(posedge clk) begin
        div_valid <= 1'b0;
        if (dm_cnt > 1) begin
            dm_cnt <= dm_cnt - 1;
        end else if (dm_cnt == 1) begin
            dm_cnt    <= 0;
            div_busy  <= 1'b0;
            div_valid <= 1'b1;
            div_q     <= (dm_y == 0) ? 32'hFFFFFFFF : dm_x / dm_y;
            div_r     <= (dm_y == 0) ? dm_x : dm_x % dm_y;
        end
        if (div_start) begin
            dm_cnt   <= dm_lat;
            div_busy <= 1'b1;
            dm_x     <= div_x;
            dm_y     <= div_y;
        end
    end

    // Cycle counter and div_start monitor.
    int          cyc = 0;
    int          ds_cnt = 0;
    int          ds_cyc = -1;
    logic [31:0] ds_x = '0, ds_y = '0;
    always @(posedge clk) begin
        if (div_start) begin
            ds_cnt <= ds_cnt + 1;
            ds_cyc <= cyc;
            ds_x   <= div_x;
            ds_y   <= div_y;
        end
        cyc <= cyc + 1;
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        bit          start;
        logic [31:0] x;
        logic [31:0] y;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   acc_cyc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void add(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input int lat, input bit start,
                                input logic [31:0] x, input logic [31:0] y);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.lat = lat;
        v.start = start; v.x = x; v.y = y;
        vecs.push_back(v);
    endfunction

    // Presents one request at a negedge; returns at the negedge of cycle accept+1.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        chk("accept_ready", 32'(req_ready), 32'd1);
        acc_cyc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int n);
        n = 1;
        while (!resp_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("resp_arrives", 32'(resp_valid), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        int ds0;
        ds0 = ds_cnt;
        issue(v.op, v.a, v.b);
        wait_resp(n);
        chk("latency", 32'(n), 32'(v.lat));
        chk("result", resp_result, v.res);
        chk("div_start_pulses", 32'(ds_cnt - ds0), 32'(v.start));
        if (v.start) begin
            chk("div_start_cycle", 32'(ds_cyc), 32'(acc_cyc + 1));
            chk("div_x_at_start", ds_x, v.x);
            chk("div_y_at_start", ds_y, v.y);
            chk("div_x_held", div_x, v.x);
            chk("div_y_held", div_y, v.y);
        end
        @(negedge clk);
        chk("resp_drop", 32'(resp_valid), 32'd0);
        chk("idle_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_div_start"}, 32'(div_start), 32'd0);
        chk({tag, "_resp_result"}, resp_result, 32'd0);
        chk({tag, "_div_x"}, div_x, 32'd0);
        chk({tag, "_div_y"}, div_y, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        int busy_low;
        int rdy_cyc;
        vec_t v;

        // op, rs1, rs2, result, latency, div_start, |rs1|, |rs2|
        add(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 3, 1'b0, 32'h0, 32'h0);
        add(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 3, 1'b0, 32'h0, 32'h0);
        add(3'd0, 32'd7,        32'd6,        32'd42,       3, 1'b0, 32'h0, 32'h0);
        add(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, 1'b0, 32'h0, 32'h0);
        add(3'd0, 32'h12345678, 32'h00000010, 32'h23456780, 3, 1'b0, 32'h0, 32'h0);
        add(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT + 3, 1'b1, 32'd7, 32'd2);
        add(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT + 3, 1'b1, 32'd7, 32'd2);
        add(3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        DIV_LAT + 3, 1'b1, 32'd7, 32'd2);
        add(3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT + 3, 1'b1, 32'd7, 32'd2);
        add(3'd5, 32'd100,      32'd7,        32'd14,       DIV_LAT + 3, 1'b1, 32'd100, 32'd7);
        add(3'd7, 32'd100,      32'd7,        32'd2,        DIV_LAT + 3, 1'b1, 32'd100, 32'd7);
        add(3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0,        DIV_LAT + 3, 1'b1, 32'h80000000, 32'hFFFFFFFF);
        add(3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 1'b0, 32'h0, 32'h0);
        add(3'd7, 32'd5,        32'd0,        32'd5,        1, 1'b0, 32'h0, 32'h0);
        add(3'd6, 32'd5,        32'd0,        32'd5,        1, 1'b0, 32'h0, 32'h0);
        add(3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 1'b0, 32'h0, 32'h0);
        add(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b0, 32'h0, 32'h0);
        add(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 1'b0, 32'h0, 32'h0);

        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_rs1 = '0; req_rs2 = '0;
        resp_ready = 1'b1; flush = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        rst = 1'b0;
        @(negedge clk);

        // Flush in IDLE blocks a simultaneous request.
        flush = 1'b1; req_valid = 1'b1; req_op = 3'd0; req_rs1 = 32'd7; req_rs2 = 32'd6;
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        chk("idle_flush_busy", 32'(busy), 32'd0);
        chk("idle_flush_ready", 32'(req_ready), 32'd1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure in DONE.
        resp_ready = 1'b0;
        issue(3'd0, 32'd7, 32'd6);
        wait_resp(n);
        chk("bp_latency", 32'(n), 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_resp_valid", 32'(resp_valid), 32'd1);
            chk("bp_result", resp_result, 32'd42);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(resp_valid), 32'd0);
        chk("bp_release_ready", 32'(req_ready), 32'd1);
        chk("bp_release_busy", 32'(busy), 32'd0);

        // Flush while the divider still has ~10 cycles to go.
        dm_lat = 12;
        issue(3'd4, 32'hFFFFFFF9, 32'd2);
        @(negedge clk);
        chk("drain_pre_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("drain_entry_ready", 32'(req_ready), 32'd0);
        chk("drain_entry_busy", 32'(busy), 32'd1);
        chk("drain_entry_resp", 32'(resp_valid), 32'd0);
        busy_low = -1;
        rdy_cyc  = -1;
        for (int i = 0; i < 40 && rdy_cyc < 0; i++) begin
            @(negedge clk);
            chk("drain_no_resp", 32'(resp_valid), 32'd0);
            if (div_busy)
                chk("drain_ready_while_div_busy", 32'(req_ready), 32'd0);
            else if (busy_low < 0)
                busy_low = cyc;
            if (req_ready)
                rdy_cyc = cyc;
        end
        chk("drain_exit_cycle", 32'(rdy_cyc), 32'(busy_low + 1));
        chk("drain_exit_div_idle", 32'(div_busy), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("drain_late_valid_ignored", 32'(resp_valid), 32'd0);
        end
        dm_lat = DIV_LAT;
        v = vecs[9];
        run_vec(v);

        // Reset during MUL_WAIT.
        issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("rst_mul_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_mul");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mul_no_resp", 32'(resp_valid), 32'd0);

        // Reset during DONE.
        resp_ready = 1'b0;
        issue(3'd0, 32'd7, 32'd6);
        wait_resp(n);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_done");
        rst = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("rst_done_idle_ready", 32'(req_ready), 32'd1);
        run_vec(vecs[2]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
